// File: rtl/display_scan_if.sv
// display_scan_if: input/output bundle of the 7-segment scan driver.
// master: enable, bcd_bus, points, div_load, brightness, lzb_en (and blink_mask when
//         DISPLAY_SCAN_BLINK_EN is defined) out; catodes, segments, digit_idx, frame_start in.
// slave:  the mirror image, used by display_scan_drv.
interface display_scan_if #(
  parameter int NDIGITS  = 4,
  parameter int DIV_W    = 16,
  parameter int BRIGHT_W = 4
);
  localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  logic                   enable;
  logic [4*NDIGITS-1:0]   bcd_bus;
  logic [NDIGITS-1:0]     points;
  logic [DIV_W-1:0]       div_load;
  logic [BRIGHT_W-1:0]    brightness;
  logic                   lzb_en;
`ifdef DISPLAY_SCAN_BLINK_EN
  logic [NDIGITS-1:0]     blink_mask;
`endif
  logic [NDIGITS-1:0]     catodes;
  logic [7:0]             segments;
  logic [IW-1:0]          digit_idx;
  logic                   frame_start;
  modport master (
    output enable, bcd_bus, points, div_load, brightness, lzb_en,
`ifdef DISPLAY_SCAN_BLINK_EN
    output blink_mask,
`endif
    input  catodes, segments, digit_idx, frame_start
  );
  modport slave (
    input  enable, bcd_bus, points, div_load, brightness, lzb_en,
`ifdef DISPLAY_SCAN_BLINK_EN
    input  blink_mask,
`endif
    output catodes, segments, digit_idx, frame_start
  );
endinterface

// File: rtl/display_scan_drv.sv
// display_scan_drv: time-multiplexed N-digit 7-segment driver with dead time, PWM, LZB, frame snapshots.
// Ports: clk, rst_n (async active-low), bus (display_scan_if.slave: scan controls and data in,
//        catodes/segments/digit_idx/frame_start out, all outputs registered).
// Optional: define DISPLAY_SCAN_BLINK_EN to add blink_mask and the BLINK_W frame counter.
module display_scan_drv #(
  parameter int NDIGITS        = 4,
  parameter int DIV_W          = 16,
  parameter int DEAD           = 2,
  parameter int BRIGHT_W       = 4,
  parameter int CAT_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
`ifdef DISPLAY_SCAN_BLINK_EN
  ,
  parameter int BLINK_W        = 6
`endif
) (
  input logic           clk,
  input logic           rst_n,
  display_scan_if.slave bus
);
  localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  localparam logic [NDIGITS-1:0] CAT_OFF = CAT_ACTIVE_LOW != 0 ? '1 : '0;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  // run=0 marks the preamble cycle after reset or enable rise: it loads the
  // snapshot and the slot length so the first slot starts fully coherent.
  logic                 run, z, lit, slot_end, start;
  logic [IW-1:0]        pos;
  logic [DIV_W-1:0]     c, slot_last;
  logic [BRIGHT_W-1:0]  pwm_cnt;
  logic [4*NDIGITS-1:0] bcd_s;
  logic [NDIGITS-1:0]   pts_s, blank, sel;
  logic                 lzb_s;
  logic [3:0]           nib;
`ifdef DISPLAY_SCAN_BLINK_EN
  logic [BLINK_W-1:0]   fcnt;
  logic [NDIGITS-1:0]   mask_s;
  logic                 blink_s;
`endif
  always_comb begin
    z = lzb_s;
    blank = '0;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      z = z && bcd_s[4*i +: 4] == 4'h0 && !pts_s[i];
      blank[i] = z;
    end
`ifdef DISPLAY_SCAN_BLINK_EN
    blank = blink_s ? blank | mask_s : blank;
`endif
  end
  assign nib      = bcd_s[{pos, 2'b00} +: 4];
  assign slot_end = c == slot_last;
  assign start    = !run || (slot_end && pos == IW'(NDIGITS - 1));
  assign lit      = run && c >= DIV_W'(DEAD) && (&bus.brightness || pwm_cnt < bus.brightness) && !blank[pos];
  assign sel      = lit ? NDIGITS'(1) << pos : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run             <= 1'b0;
      pos             <= '0;
      c               <= '0;
      slot_last       <= '0;
      pwm_cnt         <= '0;
      bcd_s           <= '0;
      pts_s           <= '0;
      lzb_s           <= 1'b0;
      bus.catodes     <= CAT_OFF;
      bus.segments    <= SEG_OFF;
      bus.digit_idx   <= '0;
      bus.frame_start <= 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
      fcnt            <= '0;
      mask_s          <= '0;
      blink_s         <= 1'b0;
`endif
    end else if (!bus.enable) begin
      run             <= 1'b0;
      pos             <= '0;
      c               <= '0;
      pwm_cnt         <= '0;
      bus.catodes     <= CAT_OFF;
      bus.segments    <= SEG_OFF;
      bus.digit_idx   <= '0;
      bus.frame_start <= 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
      fcnt            <= '0;
`endif
    end else begin
      run             <= 1'b1;
      pwm_cnt         <= pwm_cnt + 1'b1;
      bus.frame_start <= start;
      if (start) begin
        pos       <= '0;
        c         <= '0;
        slot_last <= bus.div_load;
        bcd_s     <= bus.bcd_bus;
        pts_s     <= bus.points;
        lzb_s     <= bus.lzb_en;
`ifdef DISPLAY_SCAN_BLINK_EN
        // the frame takes the pre-increment count, so frame 0 after start is unblinked
        fcnt      <= fcnt + 1'b1;
        blink_s   <= fcnt[BLINK_W-1];
        mask_s    <= bus.blink_mask;
`endif
      end else if (slot_end) begin
        pos       <= pos + 1'b1;
        c         <= '0;
        slot_last <= bus.div_load;
      end else
        c <= c + 1'b1;
      // segments follow the scanned digit even in dead time, so they settle before the cathode lights
      bus.catodes   <= CAT_OFF ^ sel;
      bus.segments  <= SEG_OFF ^ (run && !blank[pos] ? {pts_s[pos], FONT[nib]} : 8'h00);
      bus.digit_idx <= pos;
    end
endmodule

// File: doc/display_scan_drv.md
Name: display_scan_drv

Overview:
Parametrised time-multiplexed driver for N common-cathode/anode 7-segment digits. It takes packed hex nibbles plus decimal points and scans one digit per slot. A programmable slot length replaces the per-clock scan of the first-generation driver. Adds a per-slot dead time (anti-ghosting), PWM brightness, leading-zero blanking and frame-coherent input snapshots. Sits between register/counter logic and the board pins.

Parameters:
NDIGITS, 4, number of digits (>=1); digit NDIGITS-1 is most significant
DIV_W, 16, width of slot-length input
DEAD, 2, cycles at start of each slot with all cathodes inactive; must be < div_load+1 or digits never light
BRIGHT_W, 4, brightness/PWM counter width
CAT_ACTIVE_LOW, 1, 1: cathode select active-low
SEG_ACTIVE_LOW, 0, 1: segment outputs inverted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable
bcd_bus  in  4*NDIGITS  digit i = bcd_bus[4i+3:4i], hex 0-F
points  in  NDIGITS  decimal point per digit
div_load  in  DIV_W  slot length minus 1, in clk cycles
brightness  in  BRIGHT_W  duty; 0 = off, all-ones = full on
lzb_en  in  1  leading-zero blanking enable
catodes  out  NDIGITS  digit select, polarity per CAT_ACTIVE_LOW
segments  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
digit_idx  out  max(1,clog2(NDIGITS))  digit currently scanned
frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (async, rst_n=0): pos=0, slot counter=0, pwm_cnt=0, snapshot=0; catodes all inactive; segments all inactive; digit_idx=0; frame_start=0.
- Slot counter c counts 0..slot_len-1, where slot_len=div_load+1. div_load is latched at slot start, so mid-slot changes take effect at the next slot. div_load=0 gives 1-cycle slots.
- At c=slot_len-1, pos advances. Scan order is 0,1,...,NDIGITS-1 and wraps to 0.
- At the wrap to 0, and on the first slot after enable rises:
  - snapshot registers capture bcd_bus, points and lzb_en;
  - frame_start=1 for that cycle.
  - Mid-frame input changes are not displayed until the next frame.
- pwm_cnt is a free-running BRIGHT_W counter, incremented every enabled cycle.
- Digit lit iff all of:
  - c >= DEAD;
  - brightness is all-ones, or pwm_cnt < brightness;
  - digit not blanked.
- Output timing: catodes, segments and digit_idx are registered, 1-cycle latency from internal state. Segments update during dead time so pattern changes never coincide with a lit cathode. A non-lit digit's cathode is inactive.
- Decode (active-high before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. dp = snapshot point.
- Leading-zero blanking (lzb_en snapshot=1):
  - scanning from digit NDIGITS-1 downward, digits with nibble 0 and point 0 are blanked until the first nonzero nibble or set point;
  - digit 0 is never blanked;
  - blanked digit: segments inactive, cathode inactive.
- enable=0, synchronous:
  - next cycle all cathodes and segments are inactive;
  - pos, c and pwm_cnt are cleared and held;
  - frame_start stays 0.
  - Re-enable starts a new frame at digit 0.
- Reset mid-slot: immediate return to reset values; no partial slot resumes.

Optional Feature:
DISPLAY_SCAN_BLINK_EN:
- Defined:
  - adds input blink_mask [NDIGITS] and parameter BLINK_W (default 6);
  - a BLINK_W frame counter increments at each frame_start;
  - while its MSB=1, digits with blink_mask bit set (captured in the snapshot) are blanked like leading zeros.
  - The counter resets to 0 on rst_n and is held at 0 while enable=0.
- Undefined: port, parameter and counter are absent; no blinking.

Test Plan:
1. Reset with NDIGITS=4, CAT_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0: assert rst_n=0 asynchronously mid-slot -> catodes=4'b1111 and segments=8'h00 immediately; digit_idx=0.
2. Basic scan: div_load=9, DEAD=2, brightness=4'hF, bcd_bus=16'h1234, points=0 -> 10-cycle slots, 40-cycle frames with frame_start every 40. Each digit's cathode is active for slot cycles 2..9, observed one cycle later. Digit 0 segments=8'h66, digit 3 segments=8'h06.
3. LZB: lzb_en=1, bcd_bus=16'h0050 -> digits 3 and 2 dark, digit 1=8'h6D, digit 0=8'h3F. With bcd_bus=16'h0000, only digit 0 lit (8'h3F). With points=4'b0100, digit 2 shows 8'hBF.
4. Brightness: brightness=4 with div_load=63 -> within each slot's non-dead window the cathode is active only while pwm_cnt<4 (4/16 duty). brightness=0 -> cathodes never active.
5. Snapshot: change bcd_bus from 16'h1234 to 16'h9999 during digit 1's slot -> remaining digits of that frame show 2,1. All digits show 9 (8'h6F) after the next frame_start.
6. Enable drop during digit 2 -> next cycle all outputs inactive. Re-raise enable -> frame_start pulses, scan restarts at digit 0. Under DISPLAY_SCAN_BLINK_EN, BLINK_W=2 and blink_mask=4'b0001 -> digit 0 dark in frames 2,3, lit in 0,1, repeating.
